// File: rtl/mach_dieu_khien_xe_oto_if.sv
// mach_dieu_khien_xe_oto_if: driver request inputs and speed level output
interface mach_dieu_khien_xe_oto_if;
  logic brake;
  logic accelerate;
  logic [1:0] w;
  modport master(output brake, output accelerate, input w);
  modport slave(input brake, input accelerate, output w);
endinterface

// File: rtl/mach_dieu_khien_xe_oto.sv
// mach_dieu_khien_xe_oto: four-level saturating speed FSM, brake has priority over accelerate
module mach_dieu_khien_xe_oto (
  input  logic clk,
  input  logic reset,
  mach_dieu_khien_xe_oto_if.slave bus
);
  typedef enum logic [1:0] {STOP = 2'b00, SLOW = 2'b01, MEDIUM = 2'b10, FAST = 2'b11} state_t;
  state_t state, next;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= STOP;
    else state <= next;
  always_comb
    next = bus.brake      ? (state == STOP ? STOP : state_t'(state - 2'd1)) :
           bus.accelerate ? (state == FAST ? FAST : state_t'(state + 2'd1)) : state;
  always_comb bus.w = state;
endmodule

// File: tb/tb_mach_dieu_khien_xe_oto.sv
// tb_mach_dieu_khien_xe_oto: table-driven vectors plus hand sequences for reset, priority and hold
module tb_mach_dieu_khien_xe_oto;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  mach_dieu_khien_xe_oto_if bus();
  mach_dieu_khien_xe_oto dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic       accelerate;
    logic       brake;
    logic [1:0] w;
  } vec_t;
  vec_t vecs[16];

  task automatic check(input string name, input logic [1:0] exp);
    total++;
    if (bus.w !== exp) begin
      bad++;
      $display("FAIL %s: w=%b expected %b at %0t", name, bus.w, exp, $time);
    end
  endtask

  task automatic step(input logic a, input logic b, input logic [1:0] exp, input string name);
    bus.accelerate = a;
    bus.brake = b;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_async", 2'b00);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs = '{
      '{1'b1, 1'b0, 2'b01}, '{1'b1, 1'b0, 2'b10}, '{1'b1, 1'b0, 2'b11}, '{1'b1, 1'b0, 2'b11},
      '{1'b0, 1'b1, 2'b10}, '{1'b0, 1'b1, 2'b01}, '{1'b0, 1'b1, 2'b00}, '{1'b0, 1'b1, 2'b00},
      '{1'b1, 1'b0, 2'b01}, '{1'b1, 1'b0, 2'b10}, '{1'b1, 1'b1, 2'b01}, '{1'b0, 1'b1, 2'b00},
      '{1'b0, 1'b0, 2'b00}, '{1'b0, 1'b1, 2'b00}, '{1'b1, 1'b1, 2'b00}, '{1'b0, 1'b1, 2'b00}
    };
    bus.accelerate = 1'b1;
    bus.brake = 1'b0;
    #1;
    check("reset_hold_t0", 2'b00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check("reset_hold_edge", 2'b00);
    end
    @(negedge clk);
    reset = 1'b0;
    // ramp up, ramp down, then the mixed sequence from STOP
    for (int i = 0; i < 16; i++)
      step(vecs[i].accelerate, vecs[i].brake, vecs[i].w, $sformatf("vec%0d", i));
    step(1'b1, 1'b0, 2'b01, "to_slow");
    step(1'b1, 1'b0, 2'b10, "to_medium");
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_mid", 2'b00);
    #1;
    check("async_reset_before_edge", 2'b00);
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 1'b0, 2'b01, "prio_up1");
    step(1'b1, 1'b0, 2'b10, "prio_up2");
    step(1'b1, 1'b1, 2'b01, "prio_medium_both");
    do_reset();
    step(1'b1, 1'b1, 2'b00, "prio_stop_both");
    step(1'b1, 1'b0, 2'b01, "hold_setup");
    for (int i = 0; i < 3; i++) begin
      bus.accelerate = 1'b0;
      bus.brake = 1'b0;
      #2;
      bus.accelerate = 1'b1;
      #1;
      check("glitch_acc", 2'b01);
      bus.accelerate = 1'b0;
      bus.brake = 1'b1;
      #1;
      check("glitch_brk", 2'b01);
      bus.brake = 1'b0;
      step(1'b0, 1'b0, 2'b01, "hold_slow");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
